// File: rtl/dsram_responder_pkg.sv
// Shared definitions for the data-SRAM responder: FSM encoding and derived widths.
package dsram_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_WD      = $clog2(LATENCY_MAX + 1);

  function automatic int mask_wd(input int data_wd);
    return data_wd / 8;
  endfunction

endpackage

// File: rtl/dsram_responder_array.sv
// Word-addressed storage array with byte-masked writes and a registered read port.
// Latency: read data valid the cycle after rd_en; write committed at the same edge.
// Backpressure: none; the owner issues at most one access per cycle.
module dsram_responder_array
  import dsram_responder_pkg::*;
#(
  parameter int DATA_WD    = 64,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                        core_clk,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic [DEPTH_LOG2-1:0]       idx,
  input  logic [mask_wd(DATA_WD)-1:0] wmask,
  input  logic [DATA_WD-1:0]          wdata,
  output logic [DATA_WD-1:0]          rdata
);

  logic [DATA_WD-1:0] mem [2**DEPTH_LOG2];

  // Contents and read register are deliberately unreset so this maps onto SRAM macros.
  always_ff @(posedge core_clk) begin
    if (wr_en) begin
      for (int b = 0; b < mask_wd(DATA_WD); b++) begin
        if (wmask[b]) begin
          mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dsram_responder.sv
// Memory-side responder for the data-SRAM interface: one load/store outstanding.
// Latency: response valid LATENCY edges after the accept edge (accept edge counts as the first).
// Backpressure: response held stable until i_resp_ready; requests refused outside IDLE.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int                 WORD_WD      = 64,
  parameter int                 SRAM_DATA_WD = 64,
  parameter int                 ADDR_WD      = 32,
  parameter int                 DEPTH_LOG2   = 12,
  parameter logic [ADDR_WD-1:0] BASE_ADDR    = 32'h8000_0000,
  parameter int                 LATENCY      = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic                             i_req_wen,
  input  logic [ADDR_WD-1:0]               i_req_addr,
  input  logic [mask_wd(SRAM_DATA_WD)-1:0] i_req_wmask,
  input  logic [SRAM_DATA_WD-1:0]          i_req_wdata,
  output logic                             o_resp_valid,
  input  logic                             i_resp_ready,
  output logic [SRAM_DATA_WD-1:0]          o_resp_rdata,
  output logic                             o_resp_err
);

  if (WORD_WD != SRAM_DATA_WD) begin : g_bad_word_wd
    $error("dsram_responder: WORD_WD must equal SRAM_DATA_WD");
  end
  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dsram_responder: LATENCY must be in 1..15");
  end

  logic [1:0]            state_r;
  logic [CNT_WD-1:0]     cnt_r;
  logic                  err_r;
  logic                  rd_ok_r;
  logic [ADDR_WD-1:0]    offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  arr_wr_en;
  logic                  arr_rd_en;
  logic [WORD_WD-1:0]    arr_rdata;
  logic                  unused_offset_lsbs;

  // Unsigned wrap makes addresses below the base land far above the array and fail.
  assign offset             = i_req_addr - BASE_ADDR;
  assign in_range           = (offset >> (DEPTH_LOG2 + 3)) == '0;
  assign idx                = offset[DEPTH_LOG2+2:3];
  assign unused_offset_lsbs = ^offset[2:0];

  assign o_req_ready  = (state_r == ST_IDLE);
  assign accept       = i_req_valid && o_req_ready;
  assign arr_wr_en    = accept && i_req_wen && in_range;
  assign arr_rd_en    = accept && !i_req_wen && in_range;

  dsram_responder_array #(
    .DATA_WD    (WORD_WD),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .core_clk (i_clk),
    .wr_en    (arr_wr_en),
    .rd_en    (arr_rd_en),
    .idx      (idx),
    .wmask    (i_req_wmask),
    .wdata    (i_req_wdata),
    .rdata    (arr_rdata)
  );

  // The array's read register holds load data; rd_ok_r gates it so stores/errors read 0.
  assign o_resp_valid = (state_r == ST_RESP);
  assign o_resp_rdata = rd_ok_r ? arr_rdata : '0;
  assign o_resp_err   = err_r;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      err_r   <= 1'b0;
      rd_ok_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept) begin
            cnt_r   <= CNT_WD'(LATENCY - 1);
            err_r   <= !in_range;
            rd_ok_r <= !i_req_wen && in_range;
            state_r <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - 1'b1;
          if (cnt_r == CNT_WD'(1)) begin
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_resp_ready) begin
            err_r   <= 1'b0;
            rd_ok_r <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsram_responder.sv
// Scoreboard bench for dsram_responder: LATENCY=2 main instance plus a LATENCY=1 instance.
module tb_dsram_responder;

  localparam int          LAT        = 2;
  localparam logic [31:0] BASE       = 32'h8000_0000;
  localparam logic [31:0] SPAN_BYTES = 32'h0000_8000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr;
  logic [7:0]  req_wmask;
  logic [63:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  logic        r1_req_valid, r1_req_ready, r1_req_wen;
  logic [31:0] r1_req_addr;
  logic [7:0]  r1_req_wmask;
  logic [63:0] r1_req_wdata;
  logic        r1_resp_valid, r1_resp_ready, r1_resp_err;
  logic [63:0] r1_resp_rdata;

  dsram_responder #(.LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
    .i_req_addr(req_addr), .i_req_wmask(req_wmask), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err)
  );

  dsram_responder #(.LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(r1_req_valid), .o_req_ready(r1_req_ready), .i_req_wen(r1_req_wen),
    .i_req_addr(r1_req_addr), .i_req_wmask(r1_req_wmask), .i_req_wdata(r1_req_wdata),
    .o_resp_valid(r1_resp_valid), .i_resp_ready(r1_resp_ready),
    .o_resp_rdata(r1_resp_rdata), .o_resp_err(r1_resp_err)
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  logic [63:0] mdl [bit [31:0]];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          hs_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [63:0] prev_rdata = '0;
  logic        prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: latency on the rising edge of valid, stability while stalled, scoreboard on handshake.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (!prev_valid) begin
        chk("latency", 64'(cyc - acc_cyc), 64'(LAT - 1));
      end else begin
        chk("hold_rdata", resp_rdata, prev_rdata);
        chk("hold_err", 64'(resp_err), 64'(prev_err));
      end
      chk("busy_req_ready", 64'(req_ready), 64'd0);
      if (resp_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e_mon = sb.pop_front();
          chk("rdata", resp_rdata, e_mon.rdata);
          chk("err", 64'(resp_err), 64'(e_mon.err));
        end
        hs_cyc = cyc + 1;
      end
    end
    prev_valid = rst_n && resp_valid;
    prev_rdata = resp_rdata;
    prev_err   = resp_err;
  end

  task automatic do_req(input logic wen, input logic [31:0] addr,
                        input logic [7:0] wmask, input logic [63:0] wdata);
    logic [31:0] off;
    bit   [31:0] idx;
    logic [63:0] w;
    exp_t        e;
    bit          ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wmask = wmask;
    req_wdata = wdata;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok      = 1'b1;
        off     = addr - BASE;
        idx     = off >> 3;
        e.err   = (off >= SPAN_BYTES);
        e.rdata = '0;
        if (!e.err) begin
          if (wen) begin
            w = mdl.exists(idx) ? mdl[idx] : 64'hx;
            for (int b = 0; b < 8; b++) if (wmask[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
            mdl[idx] = w;
          end else begin
            e.rdata = mdl.exists(idx) ? mdl[idx] : 64'hx;
          end
        end
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    acc_cyc   = cyc;
    chk("accept_timeout", 64'(ok), 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && req_ready) break;
      @(negedge clk);
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wmask = '0; req_wdata = '0;
    resp_ready = 1'b1;
    r1_req_valid = 1'b0; r1_req_wen = 1'b0; r1_req_addr = '0; r1_req_wmask = '0; r1_req_wdata = '0;
    r1_resp_ready = 1'b1;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    #8 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full store, read-back, partial store, ignored low address bits.
    do_req(1'b1, 32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788); wait_idle();
    do_req(1'b0, 32'h8000_0010, 8'h00, 64'h0);                   wait_idle();
    do_req(1'b1, 32'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB); wait_idle();
    do_req(1'b0, 32'h8000_0010, 8'h00, 64'h0);                   wait_idle();
    do_req(1'b0, 32'h8000_0013, 8'h00, 64'h0);                   wait_idle();

    // First and last words, then out-of-range loads and stores must not alias into them.
    do_req(1'b1, 32'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF); wait_idle();
    do_req(1'b1, 32'h8000_7FF8, 8'hFF, 64'hFEDC_BA98_7654_3210); wait_idle();
    do_req(1'b0, 32'h8000_7FF8, 8'h00, 64'h0);                   wait_idle();
    do_req(1'b0, 32'h7FFF_FFF8, 8'h00, 64'h0);                   wait_idle();
    do_req(1'b0, 32'h8000_8000, 8'h00, 64'h0);                   wait_idle();
    do_req(1'b1, 32'h8000_8000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF); wait_idle();
    do_req(1'b1, 32'h7FFF_FFF8, 8'hFF, 64'hCAFE_F00D_CAFE_F00D); wait_idle();
    do_req(1'b0, 32'h8000_0000, 8'h00, 64'h0);                   wait_idle();
    do_req(1'b0, 32'h8000_7FF8, 8'h00, 64'h0);                   wait_idle();

    // Zero-mask store is acknowledged and leaves the word intact.
    do_req(1'b1, 32'h8000_0010, 8'h00, 64'h5555_5555_5555_5555); wait_idle();
    do_req(1'b0, 32'h8000_0010, 8'h00, 64'h0);                   wait_idle();

    // Backpressure: stall the response while a second request waits.
    resp_ready = 1'b0;
    do_req(1'b0, 32'h8000_0000, 8'h00, 64'h0);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_wmask = '0; req_wdata = '0;
    for (int i = 0; i < 20 && !resp_valid; i++) @(posedge clk);
    chk("stall_resp_valid", 64'(resp_valid), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_req_ready", 64'(req_ready), 64'd0);
    resp_ready = 1'b1;
    do_req(1'b0, 32'h8000_0010, 8'h00, 64'h0);
    chk("accept_after_hs", 64'(acc_cyc - hs_cyc), 64'd1);
    wait_idle();

    // Asynchronous reset while WAITing after a store; the store itself must persist.
    do_req(1'b1, 32'h8000_0040, 8'hFF, 64'h0F0E_0D0C_0B0A_0908);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b0, 32'h8000_0040, 8'h00, 64'h0); wait_idle();

    // LATENCY=1 instance: store, then back-to-back loads with response ready tied high.
    r1_req_valid = 1'b1; r1_req_wen = 1'b1; r1_req_addr = 32'h8000_0020;
    r1_req_wmask = 8'hFF; r1_req_wdata = 64'h7777_6666_5555_4444;
    @(negedge clk);
    chk("l1_store_ready", 64'(r1_req_ready), 64'd1);
    @(posedge clk);
    #1;
    r1_req_valid = 1'b0;
    @(negedge clk);
    chk("l1_store_valid", 64'(r1_resp_valid), 64'd1);
    chk("l1_store_rdata", r1_resp_rdata, 64'd0);
    chk("l1_store_err", 64'(r1_resp_err), 64'd0);
    @(posedge clk);
    #1;
    r1_req_valid = 1'b1; r1_req_wen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("l1_req_ready", 64'(r1_req_ready), 64'((k % 2) == 0));
      chk("l1_resp_valid", 64'(r1_resp_valid), 64'((k % 2) == 1));
      if ((k % 2) == 1) chk("l1_rdata", r1_resp_rdata, 64'h7777_6666_5555_4444);
      @(posedge clk);
      #1;
    end
    r1_req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
